decode_stage_sequencer: RTL and testbench

- Top-level controller for the decoder flow: UART load, then Milestone 3, Milestone 2, Milestone 1, then VGA display.
- Drives each stage's start/done handshake and grants the single SRAM port to exactly one owner at a time.
- Inserts a write-safe gap cycle between owners.
- Runs a per-stage watchdog and traps into a safe error state on timeout.

---
 rtl/decode_stage_sequencer_if.sv | 37 +++
 rtl/decode_stage_sequencer.sv | 153 +++++++++++++++
 tb/tb_decode_stage_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_sequencer_if.sv
// Bundle of stage handshakes, SRAM requester buses and status seen by the decode-flow sequencer.
// The sequencer uses the master view; the surrounding datapath/testbench uses the slave view.
interface decode_stage_sequencer_if;
  logic [3:0]  skip_mask;
  logic        uart_done;
  logic [2:0]  stage_done;
  logic [2:0]  stage_start;
  logic        uart_active;
  logic [17:0] req_addr_uart, req_addr_m3, req_addr_m2, req_addr_m1, req_addr_vga;
  logic [15:0] req_wdata_uart, req_wdata_m3, req_wdata_m2, req_wdata_m1;
  logic        req_we_n_uart, req_we_n_m3, req_we_n_m2, req_we_n_m1;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        VGA_enable;
  logic [17:0] VGA_base_address;
  logic [2:0]  cur_stage;
  logic        timeout_err;

  modport master (
    input  skip_mask, uart_done, stage_done,
    input  req_addr_uart, req_addr_m3, req_addr_m2, req_addr_m1, req_addr_vga,
    input  req_wdata_uart, req_wdata_m3, req_wdata_m2, req_wdata_m1,
    input  req_we_n_uart, req_we_n_m3, req_we_n_m2, req_we_n_m1,
    output stage_start, uart_active, SRAM_address, SRAM_write_data, SRAM_we_n,
    output VGA_enable, VGA_base_address, cur_stage, timeout_err
  );

  modport slave (
    output skip_mask, uart_done, stage_done,
    output req_addr_uart, req_addr_m3, req_addr_m2, req_addr_m1, req_addr_vga,
    output req_wdata_uart, req_wdata_m3, req_wdata_m2, req_wdata_m1,
    output req_we_n_uart, req_we_n_m3, req_we_n_m2, req_we_n_m1,
    input  stage_start, uart_active, SRAM_address, SRAM_write_data, SRAM_we_n,
    input  VGA_enable, VGA_base_address, cur_stage, timeout_err
  );
endinterface

// File: rtl/decode_stage_sequencer.sv
// Sequences UART load -> M3 -> M2 -> M1 -> VGA, owning the single SRAM port,
// with a one-cycle write-safe gap between owners and a per-stage watchdog.
module decode_stage_sequencer #(
  parameter logic [3:0]  STARTUP_DELAY = 4'd10,
  parameter logic [31:0] STAGE_TIMEOUT = 32'd100_000_000,
  parameter logic [17:0] VGA_BASE      = 18'd146944
) (
  input logic                      CLOCK_50_I,
  input logic                      resetn,
  decode_stage_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_UART = 3'd1, S_M3 = 3'd2, S_M2 = 3'd3,
    S_M1   = 3'd4, S_VGA  = 3'd5, S_GAP = 3'd6, S_ERR = 3'd7
  } state_t;

  state_t      state_q, state_d, next_stage_q, next_stage_d;
  logic [3:0]  start_cnt_q, start_cnt_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  skip_q, skip_d;
  logic [2:0]  stage_start_q, stage_start_d;
  logic        uart_active_q, uart_active_d;
  logic        vga_en_q, vga_en_d;
  logic        timeout_err_q, timeout_err_d;
  logic        done_cur;
  logic        wd_expired;

  // Earliest non-skipped stage at or after 'from'; VGA when nothing is left.
  function automatic state_t first_stage_from(input state_t from, input logic [3:0] skip);
    state_t r;
    r = S_VGA;
    if (from <= S_M1   && !skip[3]) r = S_M1;
    if (from <= S_M2   && !skip[2]) r = S_M2;
    if (from <= S_M3   && !skip[1]) r = S_M3;
    if (from <= S_UART && !skip[0]) r = S_UART;
    return r;
  endfunction

  always_comb begin
    done_cur = 1'b0;
    case (state_q)
      S_UART:  done_cur = bus.uart_done;
      S_M3:    done_cur = bus.stage_done[0];
      S_M2:    done_cur = bus.stage_done[1];
      S_M1:    done_cur = bus.stage_done[2];
      default: done_cur = 1'b0;
    endcase
  end

  assign wd_expired = (STAGE_TIMEOUT != 32'd0) && (wd_q == STAGE_TIMEOUT - 32'd1);

  always_comb begin
    state_d       = state_q;
    next_stage_d  = next_stage_q;
    start_cnt_d   = start_cnt_q;
    skip_d        = skip_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (start_cnt_q == STARTUP_DELAY) begin
          skip_d  = bus.skip_mask;
          state_d = first_stage_from(S_UART, bus.skip_mask);
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      S_UART, S_M3, S_M2, S_M1: begin
        // A done in the final watchdog cycle still counts as success.
        if (done_cur) begin
          next_stage_d = first_stage_from(state_t'(state_q + 3'd1), skip_q);
          state_d      = S_GAP;
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          state_d       = S_ERR;
        end
      end
      S_GAP:   state_d = next_stage_q;
      default: state_d = state_q;
    endcase

    if (state_d != state_q)        wd_d = 32'd0;
    else if (wd_q == 32'hFFFF_FFFF) wd_d = wd_q;
    else                           wd_d = wd_q + 32'd1;

    stage_start_d = {state_d == S_M1, state_d == S_M2, state_d == S_M3};
    uart_active_d = (state_d == S_UART);
    vga_en_d      = (state_d == S_VGA);
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      next_stage_q  <= S_IDLE;
      start_cnt_q   <= 4'd0;
      wd_q          <= 32'd0;
      skip_q        <= 4'd0;
      stage_start_q <= 3'd0;
      uart_active_q <= 1'b0;
      vga_en_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_stage_q  <= next_stage_d;
      start_cnt_q   <= start_cnt_d;
      wd_q          <= wd_d;
      skip_q        <= skip_d;
      stage_start_q <= stage_start_d;
      uart_active_q <= uart_active_d;
      vga_en_q      <= vga_en_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // SRAM ownership follows the registered state only, so non-owners can never write.
  always_comb begin
    bus.SRAM_address    = 18'd0;
    bus.SRAM_write_data = 16'd0;
    bus.SRAM_we_n       = 1'b1;
    case (state_q)
      S_UART: begin
        bus.SRAM_address    = bus.req_addr_uart;
        bus.SRAM_write_data = bus.req_wdata_uart;
        bus.SRAM_we_n       = bus.req_we_n_uart;
      end
      S_M3: begin
        bus.SRAM_address    = bus.req_addr_m3;
        bus.SRAM_write_data = bus.req_wdata_m3;
        bus.SRAM_we_n       = bus.req_we_n_m3;
      end
      S_M2: begin
        bus.SRAM_address    = bus.req_addr_m2;
        bus.SRAM_write_data = bus.req_wdata_m2;
        bus.SRAM_we_n       = bus.req_we_n_m2;
      end
      S_M1: begin
        bus.SRAM_address    = bus.req_addr_m1;
        bus.SRAM_write_data = bus.req_wdata_m1;
        bus.SRAM_we_n       = bus.req_we_n_m1;
      end
      S_VGA:   bus.SRAM_address = bus.req_addr_vga;
      default: bus.SRAM_address = 18'd0;
    endcase
  end

  assign bus.stage_start      = stage_start_q;
  assign bus.uart_active      = uart_active_q;
  assign bus.VGA_enable       = vga_en_q;
  assign bus.VGA_base_address = VGA_BASE;
  assign bus.cur_stage        = state_q;
  assign bus.timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_decode_stage_sequencer.sv
// Randomized bench for decode_stage_sequencer: a per-run schedule of stage occupancy is
// computed from skip mask and done latencies, then every cycle's outputs are compared.
module tb_decode_stage_sequencer;
  localparam int SD   = 10;
  localparam int TO   = 50;
  localparam int MAXT = 512;

  logic CLOCK_50_I = 1'b0;
  logic resetn     = 1'b0;

  decode_stage_sequencer_if bus();

  decode_stage_sequencer #(
    .STARTUP_DELAY(4'd10),
    .STAGE_TIMEOUT(32'd50),
    .VGA_BASE     (18'd146944)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .bus       (bus)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected stage code per cycle after reset release (0 IDLE .. 7 ERROR).
  int exp_st[MAXT];
  bit done_at[MAXT];
  int lat_r[4];
  int t_end;
  int m1_entry;
  logic [3:0] cur_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Schedule: IDLE for SD+1 cycles, each active stage lasts latency+1 cycles then one GAP;
  // a latency of TO or more traps into ERROR exactly TO cycles after stage entry.
  task automatic build_model(input logic [3:0] mask);
    int t;
    bit term;
    for (int i = 0; i < MAXT; i++) begin
      exp_st[i]  = 5;
      done_at[i] = 1'b0;
    end
    m1_entry = -1;
    term = 1'b0;
    t = 0;
    for (int i = 0; i <= SD; i++) exp_st[i] = 0;
    t = SD + 1;
    for (int s = 0; s < 4; s++) begin
      if (!mask[s] && !term) begin
        if (s == 3) m1_entry = t;
        if (lat_r[s] < TO) begin
          for (int k = 0; k <= lat_r[s]; k++) exp_st[t + k] = s + 1;
          done_at[t + lat_r[s]] = 1'b1;
          exp_st[t + lat_r[s] + 1] = 6;
          t = t + lat_r[s] + 2;
        end else begin
          for (int k = 0; k < TO; k++) exp_st[t + k] = s + 1;
          for (int u = t + TO; u < MAXT; u++) exp_st[u] = 7;
          t = t + TO;
          term = 1'b1;
        end
      end
    end
    t_end = t + 6;
  endtask

  task automatic drive(input int t);
    bus.req_addr_uart  = 18'($urandom);
    bus.req_addr_m3    = 18'($urandom);
    bus.req_addr_m2    = 18'($urandom);
    bus.req_addr_m1    = 18'($urandom);
    bus.req_addr_vga   = 18'($urandom);
    bus.req_wdata_uart = 16'($urandom);
    bus.req_wdata_m3   = 16'($urandom);
    bus.req_wdata_m2   = 16'($urandom);
    bus.req_wdata_m1   = 16'($urandom);
    bus.req_we_n_uart  = 1'($urandom);
    bus.req_we_n_m3    = 1'($urandom);
    bus.req_we_n_m2    = 1'($urandom);
    bus.req_we_n_m1    = 1'($urandom);
    bus.skip_mask      = (t == SD) ? cur_mask : 4'($urandom);
    bus.uart_done      = 1'($urandom);
    bus.stage_done     = 3'($urandom);
    case (exp_st[t])
      1:       bus.uart_done     = done_at[t];
      2:       bus.stage_done[0] = done_at[t];
      3:       bus.stage_done[1] = done_at[t];
      4:       bus.stage_done[2] = done_at[t];
      default: ;
    endcase
  endtask

  task automatic check_cycle(input int e);
    logic [17:0] ea;
    logic [15:0] ed;
    logic        ew;
    ea = 18'd0; ed = 16'd0; ew = 1'b1;
    case (e)
      1: begin ea = bus.req_addr_uart; ed = bus.req_wdata_uart; ew = bus.req_we_n_uart; end
      2: begin ea = bus.req_addr_m3;   ed = bus.req_wdata_m3;   ew = bus.req_we_n_m3;   end
      3: begin ea = bus.req_addr_m2;   ed = bus.req_wdata_m2;   ew = bus.req_we_n_m2;   end
      4: begin ea = bus.req_addr_m1;   ed = bus.req_wdata_m1;   ew = bus.req_we_n_m1;   end
      5: ea = bus.req_addr_vga;
      default: ;
    endcase
    chk("cur_stage",   32'(bus.cur_stage),   32'(e));
    chk("stage_start", 32'(bus.stage_start), 32'({e == 4, e == 3, e == 2}));
    chk("uart_active", 32'(bus.uart_active), 32'(e == 1));
    chk("vga_enable",  32'(bus.VGA_enable),  32'(e == 5));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e == 7));
    chk("sram_addr",   32'(bus.SRAM_address),    32'(ea));
    chk("sram_wdata",  32'(bus.SRAM_write_data), 32'(ed));
    chk("sram_we_n",   32'(bus.SRAM_we_n),       32'(ew));
    chk("vga_base",    32'(bus.VGA_base_address), 32'(18'd146944));
  endtask

  // abort_mode: 0 run to completion, -1 reset three cycles into M1, >0 reset at that cycle.
  task automatic run_case(input logic [3:0] mask, input int abort_mode);
    int tstop;
    cur_mask = mask;
    build_model(mask);
    tstop = t_end;
    if (abort_mode > 0 && abort_mode < t_end) tstop = abort_mode;
    if (abort_mode < 0 && m1_entry >= 0) tstop = m1_entry + 3;
    @(negedge CLOCK_50_I);
    drive(0);
    resetn = 1'b1;
    #1 check_cycle(0);
    for (int t = 1; t <= tstop; t++) begin
      @(posedge CLOCK_50_I);
      @(negedge CLOCK_50_I);
      check_cycle(exp_st[t]);
      drive(t);
    end
    // Asynchronous reset mid-cycle must clear starts and SRAM ownership immediately.
    #2 resetn = 1'b0;
    #1 check_cycle(0);
    repeat (2) @(posedge CLOCK_50_I);
    #1 check_cycle(0);
  endtask

  initial begin
    cur_mask = 4'd0;
    for (int i = 0; i < MAXT; i++) begin
      exp_st[i] = 0;
      done_at[i] = 1'b0;
    end
    drive(0);
    repeat (3) @(negedge CLOCK_50_I);
    check_cycle(0);

    lat_r = '{20, 20, 20, 20};
    run_case(4'b0001, 0);
    run_case(4'b1111, 0);
    lat_r = '{40, 7, 3, 9};
    run_case(4'b0000, 0);
    lat_r = '{20, 5, 200, 20};
    run_case(4'b0001, 0);
    lat_r = '{20, 20, 20, 49};
    run_case(4'b0000, 0);
    lat_r = '{3, 4, 5, 6};
    run_case(4'b0000, -1);
    lat_r = '{0, 0, 0, 0};
    run_case(4'b0110, 0);

    for (int r = 0; r < 25; r++) begin
      logic [3:0] m;
      int ab;
      for (int s = 0; s < 4; s++) begin
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 7)       lat_r[s] = int'($urandom_range(0, 30));
        else if (k == 7) lat_r[s] = TO - 1;
        else if (k == 8) lat_r[s] = TO - 2;
        else             lat_r[s] = 200;
      end
      m  = 4'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 120)) : 0;
      run_case(m, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
